// File: rtl/security_panel.sv
// -----------------------------------------------------------------------------
// security_panel
//   Intrusion panel controller: arm/disarm with a keypad code, one delayed
//   entry zone (zone 0) plus instant zones, sticky record of the zones that
//   caused the intrusion.
//
//   Optional feature macro: LOCKOUT_EN
//     defined   -> MAX_FAIL consecutive wrong disarm codes enter LOCKOUT for
//                  LOCKOUT_CYCLES cycles, then ALARM.
//     undefined -> no fail counter, no LOCKOUT state, locked tied to 0.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high; enters ARMED
//   command       0 none, 1 arm, 2 disarm, 3 ignored
//   digit         keypad digit, sampled when digit_entered=1
//   digit_entered single-cycle digit strobe
//   trigger       per-zone sensor inputs
//   bypass        per-zone bypass; a zone is active when trigger & ~bypass
//   armed         ARMED / ENTRY_DLY / DIS_ENTRY / ALARM / LOCKOUT
//   alarm         ALARM / LOCKOUT
//   pending       ENTRY_DLY / DIS_ENTRY entered from ENTRY_DLY
//   locked        LOCKOUT
//   alarm_zones   sticky OR of active zones seen while armed
// -----------------------------------------------------------------------------
module security_panel #(
    parameter int                   PIN_LEN        = 4,
    parameter logic [4*PIN_LEN-1:0] PIN            = 16'h1234,
    parameter int                   ZONES          = 4,
    parameter int                   ENTRY_DELAY    = 8,
    parameter int                   MAX_FAIL       = 3,
    parameter int                   LOCKOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       command,
    input  logic [3:0]       digit,
    input  logic             digit_entered,
    input  logic [ZONES-1:0] trigger,
    input  logic [ZONES-1:0] bypass,
    output logic             armed,
    output logic             alarm,
    output logic             pending,
    output logic             locked,
    output logic [ZONES-1:0] alarm_zones
);

    localparam int             IW         = (PIN_LEN > 1) ? $clog2(PIN_LEN) : 1;
    localparam int             TW         = $clog2(ENTRY_DELAY + 1);
    localparam logic [IW-1:0]  LAST_IDX   = IW'(PIN_LEN - 1);
    localparam logic [1:0]     CMD_ARM    = 2'd1;
    localparam logic [1:0]     CMD_DISARM = 2'd2;

`ifdef LOCKOUT_EN
    typedef enum logic [2:0] {
        DISARMED, ARM_ENTRY, ARMED, ENTRY_DLY, DIS_ENTRY, ALARM, LOCKOUT
    } state_t;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
`else
    typedef enum logic [2:0] {
        DISARMED, ARM_ENTRY, ARMED, ENTRY_DLY, DIS_ENTRY, ALARM
    } state_t;
    // Lockout parameters have no effect in this build; the empty block only
    // keeps them referenced so both builds share one parameter list.
    if (MAX_FAIL < 0 || LOCKOUT_CYCLES < 0) begin : g_lockout_params_unused
    end
`endif

    state_t           state, state_n;
    state_t           origin, origin_n;     // state that DIS_ENTRY was entered from
    logic [TW-1:0]    timer, timer_n;
    logic [IW-1:0]    idx, idx_n;
    logic             mismatch, mismatch_n;
    logic [ZONES-1:0] zones_n;
`ifdef LOCKOUT_EN
    logic [FW-1:0]    fail_cnt, fail_cnt_n;
    logic [LW-1:0]    lock_cnt, lock_cnt_n;
`endif

    logic [ZONES-1:0] active;
    logic             inst_hit, entry_hit, timed, timer_last;
    logic             collecting, code_done, code_ok;
    logic [3:0]       pin_digit;

    assign active     = trigger & ~bypass;
    assign inst_hit   = |active[ZONES-1:1];
    assign entry_hit  = active[0];
    assign timed      = (origin == ENTRY_DLY);
    // Timer holds the cycles left including the current one, so 1 means expiry.
    assign timer_last = (timer == TW'(1));
    assign collecting = (state == ARM_ENTRY) || (state == DIS_ENTRY);
    assign code_done  = collecting && digit_entered && (idx == LAST_IDX);

    // Expected digit for the current index; first digit is the top nibble.
    always_comb begin
        pin_digit = '0;
        for (int k = 0; k < PIN_LEN; k++)
            if (idx == IW'(k)) pin_digit = PIN[4*(PIN_LEN-1-k) +: 4];
    end

    // Only meaningful together with code_done: mismatch covers earlier digits.
    assign code_ok = !mismatch && (digit == pin_digit);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARMED;
            origin      <= ARMED;
            timer       <= '0;
            idx         <= '0;
            mismatch    <= 1'b0;
            alarm_zones <= '0;
`ifdef LOCKOUT_EN
            fail_cnt    <= '0;
            lock_cnt    <= '0;
`endif
        end else begin
            state       <= state_n;
            origin      <= origin_n;
            timer       <= timer_n;
            idx         <= idx_n;
            mismatch    <= mismatch_n;
            alarm_zones <= zones_n;
`ifdef LOCKOUT_EN
            fail_cnt    <= fail_cnt_n;
            lock_cnt    <= lock_cnt_n;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        state_n    = state;
        origin_n   = origin;
        timer_n    = timer;
        idx_n      = idx;
        mismatch_n = mismatch;
        zones_n    = alarm_zones;
`ifdef LOCKOUT_EN
        fail_cnt_n = fail_cnt;
        lock_cnt_n = lock_cnt;
`endif

        // Code collection: no early abort, verdict only on the last digit.
        if (collecting && digit_entered) begin
            if (idx == LAST_IDX) begin
                idx_n      = '0;
                mismatch_n = 1'b0;
            end else begin
                idx_n      = idx + 1'b1;
                mismatch_n = mismatch | (digit != pin_digit);
            end
        end

        case (state)
            DISARMED: begin
                if (command == CMD_ARM) begin
                    state_n    = ARM_ENTRY;
                    idx_n      = '0;
                    mismatch_n = 1'b0;
                end
            end

            ARM_ENTRY: begin
                if (code_done) state_n = code_ok ? ARMED : DISARMED;
            end

            ARMED: begin
                zones_n = alarm_zones | active;
                // Any active zone beats a disarm command in the same cycle.
                if (inst_hit) begin
                    state_n = ALARM;
                end else if (entry_hit) begin
                    state_n = ENTRY_DLY;
                    timer_n = TW'(ENTRY_DELAY);
                end else if (command == CMD_DISARM) begin
                    state_n    = DIS_ENTRY;
                    origin_n   = ARMED;
                    idx_n      = '0;
                    mismatch_n = 1'b0;
                end
            end

            ENTRY_DLY: begin
                zones_n = alarm_zones | active;
                timer_n = timer - 1'b1;
                if (inst_hit || timer_last) begin
                    state_n = ALARM;
                    timer_n = '0;
                end else if (command == CMD_DISARM) begin
                    // Timer keeps running while the code is typed.
                    state_n    = DIS_ENTRY;
                    origin_n   = ENTRY_DLY;
                    idx_n      = '0;
                    mismatch_n = 1'b0;
                end
            end

            DIS_ENTRY: begin
                if (timed) timer_n = timer - 1'b1;
                if (code_done && code_ok) begin
                    state_n = DISARMED;
                    zones_n = '0;
                    timer_n = '0;
`ifdef LOCKOUT_EN
                    fail_cnt_n = '0;
`endif
                end else if (code_done) begin
                    timer_n = '0;
`ifdef LOCKOUT_EN
                    if (fail_cnt == FW'(MAX_FAIL - 1)) begin
                        state_n    = LOCKOUT;
                        lock_cnt_n = LW'(LOCKOUT_CYCLES);
                    end else begin
                        fail_cnt_n = fail_cnt + 1'b1;
                        state_n    = timed ? ALARM : origin;
                    end
`else
                    state_n = timed ? ALARM : origin;
`endif
                end else if (timed && timer_last) begin
                    // Entry time ran out mid-code: drop the partial code.
                    state_n    = ALARM;
                    timer_n    = '0;
                    idx_n      = '0;
                    mismatch_n = 1'b0;
                end
            end

            ALARM: begin
                zones_n = alarm_zones | active;
                if (command == CMD_DISARM) begin
                    state_n    = DIS_ENTRY;
                    origin_n   = ALARM;
                    idx_n      = '0;
                    mismatch_n = 1'b0;
                end
            end

`ifdef LOCKOUT_EN
            LOCKOUT: begin
                lock_cnt_n = lock_cnt - 1'b1;
                if (lock_cnt == LW'(1)) begin
                    state_n    = ALARM;
                    fail_cnt_n = '0;
                    lock_cnt_n = '0;
                end
            end
`endif

            default: state_n = ARMED;
        endcase
    end

    // Moore output decode
    always_comb begin
        armed   = 1'b0;
        alarm   = 1'b0;
        pending = 1'b0;
        locked  = 1'b0;
        case (state)
            ARMED:     armed = 1'b1;
            ENTRY_DLY: begin armed = 1'b1; pending = 1'b1; end
            DIS_ENTRY: begin armed = 1'b1; pending = timed; end
            ALARM:     begin armed = 1'b1; alarm = 1'b1; end
`ifdef LOCKOUT_EN
            LOCKOUT:   begin armed = 1'b1; alarm = 1'b1; locked = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_security_panel.sv
// -----------------------------------------------------------------------------
// tb_security_panel
//   Scenario tasks build a per-cycle plan of inputs plus the outputs expected
//   after that cycle's clock edge. Expected values go to the scoreboard queue
//   when the stimulus is driven and are popped and compared once the edge has
//   passed. Lockout scenario adapts to the LOCKOUT_EN build.
// -----------------------------------------------------------------------------
module tb_security_panel;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] command = 2'd0;
    logic [3:0] digit = 4'd0;
    logic       digit_entered = 1'b0;
    logic [3:0] trigger = 4'd0;
    logic [3:0] bypass = 4'd0;
    logic       armed, alarm, pending, locked;
    logic [3:0] alarm_zones;

    security_panel #(
        .PIN_LEN(4), .PIN(16'h1234), .ZONES(4), .ENTRY_DELAY(8),
        .MAX_FAIL(3), .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .command(command), .digit(digit),
        .digit_entered(digit_entered), .trigger(trigger), .bypass(bypass),
        .armed(armed), .alarm(alarm), .pending(pending), .locked(locked),
        .alarm_zones(alarm_zones)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       a, al, p, l;
        logic [3:0] z;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic [1:0] cmd;
        logic       de;
        logic [3:0] dig;
        logic [3:0] trg;
        logic [3:0] byp;
        out_t       want;
    } stim_t;

    stim_t plan[$];
    out_t  sb[$];
    int    checks = 0;
    int    failures = 0;

    // Expected output patterns per visible state class
    function automatic out_t s_dis(input logic [3:0] z); return {4'b0000, z}; endfunction
    function automatic out_t s_arm(input logic [3:0] z); return {4'b1000, z}; endfunction
    function automatic out_t s_pnd(input logic [3:0] z); return {4'b1010, z}; endfunction
    function automatic out_t s_alm(input logic [3:0] z); return {4'b1100, z}; endfunction
    function automatic out_t s_lck(input logic [3:0] z); return {4'b1101, z}; endfunction

    task automatic row(input logic rst, input logic [1:0] c, input logic de,
                       input logic [3:0] d, input logic [3:0] t, input logic [3:0] b,
                       input out_t w);
        stim_t s;
        s.rst = rst; s.cmd = c; s.de = de; s.dig = d; s.trg = t; s.byp = b; s.want = w;
        plan.push_back(s);
    endtask

    task automatic idle(input out_t w);                          row(0, 0, 0, 0, 0, 0, w); endtask
    task automatic cmd(input logic [1:0] c, input out_t w);       row(0, c, 0, 0, 0, 0, w); endtask
    task automatic dig(input logic [3:0] d, input out_t w);       row(0, 0, 1, d, 0, 0, w); endtask
    task automatic trg(input logic [3:0] t, input logic [3:0] b, input out_t w);
        row(0, 0, 0, 0, t, b, w);
    endtask

    task automatic code(input logic [15:0] c, input out_t mid, input out_t fin);
        for (int k = 0; k < 4; k++) dig(c[15-4*k -: 4], (k == 3) ? fin : mid);
    endtask

    task automatic rearm();
        cmd(2'd1, s_dis(4'h0));
        code(16'h1234, s_dis(4'h0), s_arm(4'h0));
    endtask

    task automatic apply(input stim_t s);
        reset = s.rst; command = s.cmd; digit_entered = s.de; digit = s.dig;
        trigger = s.trg; bypass = s.byp;
        sb.push_back(s.want);
        @(posedge clk); #1;
        reset = 1'b0; command = 2'd0; digit_entered = 1'b0; digit = 4'd0;
        trigger = 4'd0; bypass = 4'd0;
    endtask

    task automatic test_reset();
        out_t e, got;
        plan.delete();
        row(1, 0, 0, 0, 0, 0, s_arm(4'h0));
        idle(s_arm(4'h0));
        foreach (plan[i]) begin
            apply(plan[i]);
            e = sb.pop_front(); got = {armed, alarm, pending, locked, alarm_zones};
            checks++;
            if (got !== e) begin failures++; $display("FAIL reset[%0d] got %b required %b", i, got, e); end
        end
    endtask

    task automatic test_disarm();
        out_t e, got;
        plan.delete();
        cmd(2'd2, s_arm(4'h0));
        code(16'h1234, s_arm(4'h0), s_dis(4'h0));
        idle(s_dis(4'h0));
        foreach (plan[i]) begin
            apply(plan[i]);
            e = sb.pop_front(); got = {armed, alarm, pending, locked, alarm_zones};
            checks++;
            if (got !== e) begin failures++; $display("FAIL disarm[%0d] got %b required %b", i, got, e); end
        end
    endtask

    task automatic test_arm();
        out_t e, got;
        plan.delete();
        trg(4'b1111, 4'b0000, s_dis(4'h0));      // triggers ignored while disarmed
        dig(4'd4, s_dis(4'h0));                  // stray digit ignored
        cmd(2'd1, s_dis(4'h0));
        dig(4'd1, s_dis(4'h0));
        cmd(2'd2, s_dis(4'h0));                  // command ignored during entry
        dig(4'd2, s_dis(4'h0));
        dig(4'd3, s_dis(4'h0));
        dig(4'd5, s_dis(4'h0));                  // wrong code -> DISARMED
        rearm();
        dig(4'd7, s_arm(4'h0));                  // stray digit while armed
        foreach (plan[i]) begin
            apply(plan[i]);
            e = sb.pop_front(); got = {armed, alarm, pending, locked, alarm_zones};
            checks++;
            if (got !== e) begin failures++; $display("FAIL arm[%0d] got %b required %b", i, got, e); end
        end
    endtask

    task automatic test_entry_delay();
        out_t e, got;
        plan.delete();
        trg(4'b0001, 4'b0000, s_pnd(4'b0001));
        for (int k = 0; k < 7; k++) idle(s_pnd(4'b0001));
        idle(s_alm(4'b0001));
        trg(4'b0100, 4'b0000, s_alm(4'b0101));   // alarm keeps collecting zones
        cmd(2'd2, s_arm(4'b0101));
        code(16'h1234, s_arm(4'b0101), s_dis(4'h0));
        rearm();
        foreach (plan[i]) begin
            apply(plan[i]);
            e = sb.pop_front(); got = {armed, alarm, pending, locked, alarm_zones};
            checks++;
            if (got !== e) begin failures++; $display("FAIL entry_delay[%0d] got %b required %b", i, got, e); end
        end
    endtask

    task automatic test_bypass();
        out_t e, got;
        plan.delete();
        trg(4'b0100, 4'b0100, s_arm(4'h0));      // bypassed instant zone
        trg(4'b0101, 4'b0100, s_pnd(4'b0001));
        cmd(2'd2, s_pnd(4'b0001));
        code(16'h1234, s_pnd(4'b0001), s_dis(4'h0));
        rearm();
        foreach (plan[i]) begin
            apply(plan[i]);
            e = sb.pop_front(); got = {armed, alarm, pending, locked, alarm_zones};
            checks++;
            if (got !== e) begin failures++; $display("FAIL bypass[%0d] got %b required %b", i, got, e); end
        end
    endtask

    task automatic test_wrong_codes();
        out_t e, got;
        plan.delete();
        cmd(2'd2, s_arm(4'h0));
        code(16'h1235, s_arm(4'h0), s_arm(4'h0));              // ARMED -> ARMED
        trg(4'b0001, 4'b0000, s_pnd(4'b0001));
        cmd(2'd2, s_pnd(4'b0001));
        code(16'h9999, s_pnd(4'b0001), s_alm(4'b0001));        // timed -> ALARM
        cmd(2'd2, s_arm(4'b0001));
        code(16'h1234, s_arm(4'b0001), s_dis(4'h0));
        rearm();
        foreach (plan[i]) begin
            apply(plan[i]);
            e = sb.pop_front(); got = {armed, alarm, pending, locked, alarm_zones};
            checks++;
            if (got !== e) begin failures++; $display("FAIL wrong_codes[%0d] got %b required %b", i, got, e); end
        end
    endtask

    task automatic test_timed_expiry();
        out_t e, got;
        plan.delete();
        trg(4'b0001, 4'b0000, s_pnd(4'b0001));
        cmd(2'd2, s_pnd(4'b0001));
        dig(4'd1, s_pnd(4'b0001));
        dig(4'd2, s_pnd(4'b0001));
        for (int k = 0; k < 4; k++) idle(s_pnd(4'b0001));
        idle(s_alm(4'b0001));                                   // expiry mid-code
        cmd(2'd2, s_arm(4'b0001));
        code(16'h1234, s_arm(4'b0001), s_dis(4'h0));
        rearm();
        foreach (plan[i]) begin
            apply(plan[i]);
            e = sb.pop_front(); got = {armed, alarm, pending, locked, alarm_zones};
            checks++;
            if (got !== e) begin failures++; $display("FAIL timed_expiry[%0d] got %b required %b", i, got, e); end
        end
    endtask

    task automatic test_trigger_priority();
        out_t e, got;
        plan.delete();
        row(0, 2'd2, 0, 0, 4'b0010, 4'b0000, s_alm(4'b0010));
        trg(4'b1000, 4'b0000, s_alm(4'b1010));
        foreach (plan[i]) begin
            apply(plan[i]);
            e = sb.pop_front(); got = {armed, alarm, pending, locked, alarm_zones};
            checks++;
            if (got !== e) begin failures++; $display("FAIL trigger_priority[%0d] got %b required %b", i, got, e); end
        end
    endtask

    task automatic test_lockout();
        out_t e, got;
        plan.delete();
`ifdef LOCKOUT_EN
        for (int n = 0; n < 3; n++) begin
            cmd(2'd2, s_arm(4'b1010));
            code(16'h0000, s_arm(4'b1010), (n < 2) ? s_alm(4'b1010) : s_lck(4'b1010));
        end
        for (int k = 0; k < 15; k++) begin
            if (k % 5 == 4) cmd(2'd2, s_lck(4'b1010));
            else            dig(4'(k % 5 + 1), s_lck(4'b1010));
        end
        idle(s_alm(4'b1010));
`else
        for (int n = 0; n < 3; n++) begin
            cmd(2'd2, s_arm(4'b1010));
            code(16'h0000, s_arm(4'b1010), s_alm(4'b1010));
        end
`endif
        cmd(2'd2, s_arm(4'b1010));
        code(16'h1234, s_arm(4'b1010), s_dis(4'h0));
        foreach (plan[i]) begin
            apply(plan[i]);
            e = sb.pop_front(); got = {armed, alarm, pending, locked, alarm_zones};
            checks++;
            if (got !== e) begin failures++; $display("FAIL lockout[%0d] got %b required %b", i, got, e); end
        end
    endtask

    task automatic test_reset_mid();
        out_t e, got;
        plan.delete();
        rearm();
        trg(4'b0001, 4'b0000, s_pnd(4'b0001));
        cmd(2'd2, s_pnd(4'b0001));
        dig(4'd1, s_pnd(4'b0001));
        row(1, 0, 1, 4'd2, 4'b0010, 4'b0000, s_arm(4'h0));   // reset wins over all
        idle(s_arm(4'h0));
        cmd(2'd2, s_arm(4'h0));
        code(16'h1234, s_arm(4'h0), s_dis(4'h0));
        foreach (plan[i]) begin
            apply(plan[i]);
            e = sb.pop_front(); got = {armed, alarm, pending, locked, alarm_zones};
            checks++;
            if (got !== e) begin failures++; $display("FAIL reset_mid[%0d] got %b required %b", i, got, e); end
        end
    endtask

    initial begin
        test_reset();
        test_disarm();
        test_arm();
        test_entry_delay();
        test_bypass();
        test_wrong_codes();
        test_timed_expiry();
        test_trigger_priority();
        test_lockout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
